// File: rtl/key_note_encoder_if.sv
// Key/note bundle between the raw key switches and the note encoder.
// The master side drives the raw keys; the slave side returns debounced state and note code.
interface key_note_encoder_if #(
  parameter int NUM_KEYS = 7,
  parameter int NOTE_W   = 4
);
  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] key_stable;
  logic [NUM_KEYS-1:0] led_out;
  logic [NOTE_W-1:0]   note_out;
  logic                note_valid;
  logic                note_pulse;

  modport master (
    output keys,
    input  key_stable,
    input  led_out,
    input  note_out,
    input  note_valid,
    input  note_pulse
  );

  modport slave (
    input  keys,
    output key_stable,
    output led_out,
    output note_out,
    output note_valid,
    output note_pulse
  );
endinterface

// File: rtl/key_note_encoder.sv
// MiniPiano front end: synchronises and debounces the raw keys, then resolves the
// held keys to one registered note code (0 = silence) with a new-note pulse.
module key_note_encoder #(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int NOTE_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  key_note_encoder_if.slave bus
);

  logic [NUM_KEYS-1:0] sync1_q,      sync1_d;
  logic [NUM_KEYS-1:0] sync2_q,      sync2_d;
  logic [NUM_KEYS-1:0] key_stable_q, key_stable_d;
  logic [NUM_KEYS-1:0] prev_q,       prev_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NOTE_W-1:0]   note_q,       note_d;
  logic                note_valid_q, note_valid_d;
  logic                note_pulse_q, note_pulse_d;

  logic [NUM_KEYS-1:0] mismatch;
  logic [NUM_KEYS-1:0] cnt_done;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  logic                any_rise;
  logic                cur_fell;
  logic [NOTE_W-1:0]   rise_code;
  logic [NOTE_W-1:0]   held_code;

  always_comb begin
    sync1_d = bus.keys;
    sync2_d = sync1_q;
    prev_d  = key_stable_q;
  end

  // Each key has its own counter; cnt != 0 means that key is mid-debounce.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_debounce
    assign mismatch[gi] = sync2_q[gi] ^ key_stable_q[gi];
    assign cnt_done[gi] = (cnt_q[gi] == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
      cnt_d[gi]        = cnt_q[gi];
      key_stable_d[gi] = key_stable_q[gi];
      if (!mismatch[gi]) begin
        cnt_d[gi] = '0;
      end else if (cnt_done[gi]) begin
        key_stable_d[gi] = sync2_q[gi];
        cnt_d[gi]        = '0;
      end else begin
        cnt_d[gi] = cnt_q[gi] + 1'b1;
      end
    end
  end

  // Descending scans so the lowest matching index is the one that sticks.
  always_comb begin
    rise      = key_stable_q & ~prev_q;
    fall      = ~key_stable_q & prev_q;
    any_rise  = 1'b0;
    cur_fell  = 1'b0;
    rise_code = '0;
    held_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        any_rise  = 1'b1;
        rise_code = NOTE_W'(i + 1);
      end
      if (key_stable_q[i]) begin
        held_code = NOTE_W'(i + 1);
      end
      if (fall[i] && (note_q == NOTE_W'(i + 1))) begin
        cur_fell = 1'b1;
      end
    end

    note_d = note_q;
    if (any_rise) begin
      note_d = rise_code;
    end else if (cur_fell) begin
      note_d = held_code;
    end

    note_valid_d = (note_d != '0);
    note_pulse_d = (note_d != '0) && (note_d != note_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      key_stable_q <= '0;
      prev_q       <= '0;
      cnt_q        <= '{default: '0};
      note_q       <= '0;
      note_valid_q <= 1'b0;
      note_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      key_stable_q <= key_stable_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      note_pulse_q <= note_pulse_d;
    end
  end

  assign bus.key_stable = key_stable_q;
  assign bus.led_out    = key_stable_q;
  assign bus.note_out   = note_q;
  assign bus.note_valid = note_valid_q;
  assign bus.note_pulse = note_pulse_q;

endmodule

// File: tb/tb_key_note_encoder.sv
// Directed bench for key_note_encoder with a short debounce window (4 cycles).
module tb_key_note_encoder;

  localparam int NUM_KEYS = 7;
  localparam int NOTE_W   = 4;
  localparam int DEB      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses;

  always #5 clk = ~clk;

  key_note_encoder_if #(.NUM_KEYS(NUM_KEYS), .NOTE_W(NOTE_W)) bus ();

  key_note_encoder #(
    .NUM_KEYS(NUM_KEYS),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .NOTE_W(NOTE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each; counts note_pulse highs.
  task automatic run(input int n, output int np);
    np = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.note_pulse === 1'b1) np++;
    end
  endtask

  initial begin
    bus.keys = '0;
    rst = 1'b1;
    run(2, pulses);
    chk("rst_note",   32'(bus.note_out),   0);
    chk("rst_valid",  32'(bus.note_valid), 0);
    chk("rst_pulse",  32'(bus.note_pulse), 0);
    chk("rst_stable", 32'(bus.key_stable), 0);

    // 1. idle
    rst = 1'b0;
    run(20, pulses);
    chk("idle_pulses", 32'(pulses),         0);
    chk("idle_note",   32'(bus.note_out),   0);
    chk("idle_valid",  32'(bus.note_valid), 0);
    chk("idle_led",    32'(bus.led_out),    0);

    // 2. key2 press: stable at change-edge N+5, note one edge later
    bus.keys = 7'b0000100;
    for (int k = 0; k < 5; k++) begin
      run(1, pulses);
      chk("k2_not_yet", 32'(bus.key_stable), 0);
    end
    run(1, pulses);
    chk("k2_stable",      32'(bus.key_stable), 32'h04);
    chk("k2_note_before", 32'(bus.note_out),   0);
    run(1, pulses);
    chk("k2_note",  32'(bus.note_out),   3);
    chk("k2_valid", 32'(bus.note_valid), 1);
    chk("k2_pulse", 32'(bus.note_pulse), 1);
    run(1, pulses);
    chk("k2_pulse_drop", 32'(bus.note_pulse), 0);
    bus.keys = '0;
    run(10, pulses);
    chk("k2_rel_note",   32'(bus.note_out), 0);
    chk("k2_rel_pulses", 32'(pulses),       0);

    // 3. key0 bounce 1,0,1,0 then steady 1
    bus.keys = 7'b0000001; run(1, pulses);
    bus.keys = 7'b0000000; run(1, pulses);
    bus.keys = 7'b0000001; run(1, pulses);
    bus.keys = 7'b0000000; run(1, pulses);
    chk("b_bounce_stable", 32'(bus.key_stable), 0);
    bus.keys = 7'b0000001;
    for (int k = 0; k < 5; k++) begin
      run(1, pulses);
      chk("b_not_yet", 32'(bus.key_stable), 0);
    end
    run(1, pulses);
    chk("b_stable", 32'(bus.key_stable), 32'h01);
    run(6, pulses);
    chk("b_pulses", 32'(pulses),       1);
    chk("b_note",   32'(bus.note_out), 1);
    bus.keys = '0;
    run(10, pulses);
    chk("b_rel_note", 32'(bus.note_out), 0);

    // 4. hold key1, overlay key5, release in turn
    bus.keys = 7'b0000010;
    run(10, pulses);
    chk("h1_note",   32'(bus.note_out), 2);
    chk("h1_pulses", 32'(pulses),       1);
    bus.keys = 7'b0100010;
    run(10, pulses);
    chk("h5_note",   32'(bus.note_out), 6);
    chk("h5_pulses", 32'(pulses),       1);
    bus.keys = 7'b0000010;
    run(10, pulses);
    chk("r5_note",   32'(bus.note_out), 2);
    chk("r5_pulses", 32'(pulses),       1);
    bus.keys = 7'b0000000;
    run(10, pulses);
    chk("r1_note",   32'(bus.note_out),   0);
    chk("r1_valid",  32'(bus.note_valid), 0);
    chk("r1_pulses", 32'(pulses),         0);

    // 5. keys 3 and 4 together, then release 3; then swap 4 for 0 in one edge
    bus.keys = 7'b0011000;
    run(10, pulses);
    chk("k34_note",   32'(bus.note_out), 4);
    chk("k34_led",    32'(bus.led_out),  32'h18);
    chk("k34_pulses", 32'(pulses),       1);
    bus.keys = 7'b0010000;
    run(10, pulses);
    chk("r3_note",   32'(bus.note_out), 5);
    chk("r3_pulses", 32'(pulses),       1);
    bus.keys = 7'b0000001;
    run(10, pulses);
    chk("swap_note",   32'(bus.note_out), 1);
    chk("swap_pulses", 32'(pulses),       1);
    bus.keys = 7'b0000000;
    run(10, pulses);
    chk("swap_rel_note", 32'(bus.note_out), 0);

    // 6. reset while key6 held, then re-debounce after release of reset
    bus.keys = 7'b1000000;
    run(10, pulses);
    chk("k6_note", 32'(bus.note_out), 7);
    rst = 1'b1;
    run(1, pulses);
    chk("mid_rst_note",   32'(bus.note_out),   0);
    chk("mid_rst_valid",  32'(bus.note_valid), 0);
    chk("mid_rst_pulse",  32'(bus.note_pulse), 0);
    chk("mid_rst_stable", 32'(bus.key_stable), 0);
    run(2, pulses);
    rst = 1'b0;
    run(5, pulses);
    chk("post_rst_wait_stable", 32'(bus.key_stable), 0);
    chk("post_rst_wait_pulses", 32'(pulses),         0);
    run(1, pulses);
    chk("post_rst_stable", 32'(bus.key_stable), 32'h40);
    chk("post_rst_note0",  32'(bus.note_out),   0);
    run(1, pulses);
    chk("post_rst_note",  32'(bus.note_out),   7);
    chk("post_rst_valid", 32'(bus.note_valid), 1);
    chk("post_rst_pulse", 32'(bus.note_pulse), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
